// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: saturating coin credit, per-item stock with restock, unit-wise
// change payout. Define VEND_TIMEOUT_EN to refund idle credit after TIMEOUT_CYC cycles.
module vend_ctrl_multi #(
    parameter int unsigned ITEM_N = 4,
    parameter int unsigned UNIT_W = 6,
    parameter logic [ITEM_N*UNIT_W-1:0] PRICES = {ITEM_N{UNIT_W'(3)}},
    parameter int unsigned STOCK_W = 4,
    parameter logic [STOCK_W-1:0] INIT_STOCK = STOCK_W'(8),
    parameter int unsigned TIMEOUT_CYC = 1000,
    localparam int unsigned ISEL_W = (ITEM_N > 1) ? $clog2(ITEM_N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_valid,
    input  logic [1:0]         coin,
    input  logic               sel_valid,
    input  logic [ISEL_W-1:0]  sel,
    input  logic               cancel,
    input  logic               restock,
    input  logic [ISEL_W-1:0]  restock_item,
    input  logic [STOCK_W-1:0] restock_qty,
    input  logic               change_ready,
    output logic               coin_reject,
    output logic               dispense,
    output logic [ISEL_W-1:0]  dispense_item,
    output logic [1:0]         sel_err,
    output logic               change_valid,
    output logic [UNIT_W-1:0]  credit,
    output logic               busy,
    output logic               timeout_evt
);

    typedef enum logic [1:0] {StIdle, StCredit, StDispense, StChange} state_e;

    state_e             state;
    logic [STOCK_W-1:0] stock     [ITEM_N];
    logic [STOCK_W-1:0] stock_nxt [ITEM_N];

    logic               waiting;
    logic               do_cancel;
    logic               sel_in_range;
    logic               sel_ok;
    logic               take;
    logic               restock_in_range;
    logic [STOCK_W-1:0] sel_stock;
    logic [UNIT_W-1:0]  sel_price;
    logic [UNIT_W:0]    coin_units;
    logic [UNIT_W:0]    coin_sum;
    logic               coin_ok;
    logic               tmo_hit;

    function automatic logic [STOCK_W-1:0] sat_add(input logic [STOCK_W-1:0] a,
                                                   input logic [STOCK_W-1:0] b);
        logic [STOCK_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[STOCK_W] ? '1 : s[STOCK_W-1:0];
    endfunction

    assign waiting          = (state == StIdle) || (state == StCredit);
    // Cancel only wins priority when there is credit to return; otherwise it is ignored.
    assign do_cancel        = waiting && cancel && (credit != '0);
    assign sel_in_range     = 32'(sel) < ITEM_N;
    assign restock_in_range = 32'(restock_item) < ITEM_N;
    assign sel_stock        = sel_in_range ? stock[sel] : '0;
    assign sel_price        = sel_in_range ? PRICES[32'(sel)*UNIT_W +: UNIT_W] : '0;
    assign sel_ok           = sel_in_range && (sel_stock != '0) && (credit >= sel_price);
    assign take             = waiting && !do_cancel && sel_valid && sel_ok;

    always_comb begin
        case (coin)
            2'b01:   coin_units = (UNIT_W+1)'(1);
            2'b10:   coin_units = (UNIT_W+1)'(2);
            2'b11:   coin_units = (UNIT_W+1)'(4);
            default: coin_units = '0;
        endcase
    end

    assign coin_sum = {1'b0, credit} + coin_units;
    assign coin_ok  = (coin_units != '0) && !coin_sum[UNIT_W];

    // Restock saturates first, then a same-cycle dispense of that item takes one away.
    always_comb begin
        for (int i = 0; i < ITEM_N; i++) begin
            stock_nxt[i] = stock[i];
            if (restock && restock_in_range && restock_item == ISEL_W'(i)) begin
                stock_nxt[i] = sat_add(stock[i], restock_qty);
            end
            if (take && sel == ISEL_W'(i)) begin
                stock_nxt[i] = stock_nxt[i] - STOCK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ITEM_N; i++) stock[i] <= INIT_STOCK;
        end else begin
            stock <= stock_nxt;
        end
    end

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (state == StCredit) && !coin_valid && !sel_valid &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst || state != StCredit || coin_valid || sel_valid || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= StIdle;
            credit        <= '0;
            coin_reject   <= 1'b0;
            dispense      <= 1'b0;
            dispense_item <= '0;
            sel_err       <= '0;
            change_valid  <= 1'b0;
            busy          <= 1'b0;
            timeout_evt   <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            dispense    <= 1'b0;
            sel_err     <= '0;
            timeout_evt <= 1'b0;
            case (state)
                StIdle, StCredit: begin
                    if (do_cancel) begin
                        state        <= StChange;
                        change_valid <= 1'b1;
                        busy         <= 1'b1;
                        coin_reject  <= coin_valid;
                    end else if (sel_valid) begin
                        coin_reject <= coin_valid;
                        if (!sel_in_range) begin
                            sel_err <= 2'b11;
                        end else if (sel_stock == '0) begin
                            sel_err <= 2'b10;
                        end else if (credit < sel_price) begin
                            sel_err <= 2'b01;
                        end else begin
                            credit        <= credit - sel_price;
                            state         <= StDispense;
                            dispense      <= 1'b1;
                            dispense_item <= sel;
                            busy          <= 1'b1;
                        end
                    end else if (coin_valid) begin
                        if (coin_ok) begin
                            credit <= coin_sum[UNIT_W-1:0];
                            state  <= StCredit;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        state        <= StChange;
                        change_valid <= 1'b1;
                        busy         <= 1'b1;
                        timeout_evt  <= 1'b1;
                    end
                end
                StDispense: begin
                    coin_reject <= coin_valid;
                    if (credit != '0) begin
                        state        <= StChange;
                        change_valid <= 1'b1;
                    end else begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                StChange: begin
                    coin_reject <= coin_valid;
                    if (change_ready) begin
                        credit <= credit - UNIT_W'(1);
                        if (credit == UNIT_W'(1)) begin
                            state        <= StIdle;
                            change_valid <= 1'b0;
                            busy         <= 1'b0;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Bench for vend_ctrl_multi: directed scenarios plus random traffic against a behavioural model.
module tb_vend_ctrl_multi;

    localparam int N    = 4;
    localparam int UW   = 6;
    localparam int SW   = 4;
    localparam int TCYC = 10;
    localparam int MAXC = 63;
    localparam int MAXS = 15;
    localparam logic [N*UW-1:0] PR = {6'd5, 6'd2, 6'd1, 6'd3};

    int price [N] = '{3, 1, 2, 5};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          coin_valid = 1'b0;
    logic [1:0]    coin = '0;
    logic          sel_valid = 1'b0;
    logic [1:0]    sel = '0;
    logic          cancel = 1'b0;
    logic          restock = 1'b0;
    logic [1:0]    restock_item = '0;
    logic [SW-1:0] restock_qty = '0;
    logic          change_ready = 1'b0;
    logic          coin_reject;
    logic          dispense;
    logic [1:0]    dispense_item;
    logic [1:0]    sel_err;
    logic          change_valid;
    logic [UW-1:0] credit;
    logic          busy;
    logic          timeout_evt;

    vend_ctrl_multi #(
        .ITEM_N     (N),
        .UNIT_W     (UW),
        .PRICES     (PR),
        .STOCK_W    (SW),
        .INIT_STOCK (4'd8),
        .TIMEOUT_CYC(TCYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin         (coin),
        .sel_valid    (sel_valid),
        .sel          (sel),
        .cancel       (cancel),
        .restock      (restock),
        .restock_item (restock_item),
        .restock_qty  (restock_qty),
        .change_ready (change_ready),
        .coin_reject  (coin_reject),
        .dispense     (dispense),
        .dispense_item(dispense_item),
        .sel_err      (sel_err),
        .change_valid (change_valid),
        .credit       (credit),
        .busy         (busy),
        .timeout_evt  (timeout_evt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: credit in units, stock per item, and whether an item is being released
    // or change is being paid out.
    int m_cr;
    int stk [N];
    int idle;
    bit m_disp;
    bit m_pay;
    int e_rej, e_disp, e_item, e_err, e_tmo;
    bit chk_item;

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model();
        int u;
        int tk;
        bit was_wait;
        e_rej = 0; e_disp = 0; e_err = 0; e_tmo = 0; tk = -1; chk_item = 0;
        if (!rst) begin
            m_cr = 0; m_disp = 0; m_pay = 0; idle = 0; e_item = 0; chk_item = 1;
            foreach (stk[i]) stk[i] = 8;
            return;
        end
        was_wait = !m_disp && !m_pay && m_cr > 0;
        if (was_wait && !coin_valid && !sel_valid) idle++;
        else idle = 0;
        if (m_disp) begin
            m_disp = 0;
            m_pay  = (m_cr > 0);
            e_rej  = coin_valid;
        end else if (m_pay) begin
            e_rej = coin_valid;
            if (change_ready) begin
                m_cr--;
                m_pay = (m_cr > 0);
            end
        end else if (cancel && m_cr > 0) begin
            m_pay = 1;
            e_rej = coin_valid;
        end else if (sel_valid) begin
            e_rej = coin_valid;
            if (int'(sel) >= N) e_err = 3;
            else if (stk[sel] == 0) e_err = 2;
            else if (m_cr < price[sel]) e_err = 1;
            else begin
                m_cr -= price[sel];
                tk = sel;
                m_disp = 1; e_disp = 1; e_item = sel; chk_item = 1;
            end
        end else if (coin_valid) begin
            u = (coin == 2'd1) ? 1 : (coin == 2'd2) ? 2 : (coin == 2'd3) ? 4 : 0;
            if (u == 0 || m_cr + u > MAXC) e_rej = 1;
            else m_cr += u;
        end
`ifdef VEND_TIMEOUT_EN
        else if (idle >= TCYC) begin
            m_pay = 1;
            e_tmo = 1;
        end
`endif
        if (idle >= TCYC) idle = 0;
        if (restock && int'(restock_item) < N) begin
            stk[restock_item] = (stk[restock_item] + int'(restock_qty) > MAXS) ? MAXS :
                                stk[restock_item] + int'(restock_qty);
        end
        if (tk >= 0) stk[tk]--;
    endtask

    task automatic tick();
        @(posedge clk);
        model();
        #1;
        check_eq("credit", credit, m_cr);
        check_eq("coin_reject", coin_reject, e_rej);
        check_eq("dispense", dispense, e_disp);
        check_eq("sel_err", sel_err, e_err);
        check_eq("change_valid", change_valid, m_pay);
        check_eq("busy", busy, m_disp | m_pay);
        check_eq("timeout_evt", timeout_evt, e_tmo);
        if (chk_item) check_eq("dispense_item", dispense_item, e_item);
        rst = 1'b1; coin_valid = 0; coin = '0; sel_valid = 0; sel = '0; cancel = 0;
        restock = 0; restock_item = '0; restock_qty = '0; change_ready = 0;
    endtask

    initial begin
        rst = 1'b0;
        tick();
        check_eq("reset_credit", credit, 0);

        // Three Rs.5 coins then buy item 0 (price 3).
        for (int i = 0; i < 3; i++) begin
            coin_valid = 1; coin = 2'b01; tick();
            check_eq("plan1_credit", credit, i + 1);
        end
        sel_valid = 1; sel = 2'd0; tick();
        check_eq("plan1_dispense", dispense, 1);
        tick();
        check_eq("plan1_no_change", change_valid, 0);

        // 6 units, buy item 0, three units of change.
        coin_valid = 1; coin = 2'b11; tick();
        coin_valid = 1; coin = 2'b10; tick();
        sel_valid = 1; sel = 2'd0; change_ready = 1; tick();
        for (int i = 0; i < 4; i++) begin
            change_ready = 1; tick();
        end
        check_eq("plan2_credit_end", credit, 0);

        // Saturate at 62, overflowing coin refused, coin alongside selection refused.
        for (int i = 0; i < 15; i++) begin
            coin_valid = 1; coin = 2'b11; tick();
        end
        coin_valid = 1; coin = 2'b10; tick();
        coin_valid = 1; coin = 2'b10; tick();
        check_eq("sat_reject", coin_reject, 1);
        check_eq("sat_credit", credit, 62);
        coin_valid = 1; coin = 2'b01; sel_valid = 1; sel = 2'd1; tick();
        check_eq("coin_sel_reject", coin_reject, 1);
        check_eq("coin_sel_dispense", dispense, 1);
        repeat (70) begin
            change_ready = 1; tick();
        end

        // Drain item 1, sold-out error, then restock and buy again.
        for (int g = 0; g < 20 && stk[1] > 0; g++) begin
            coin_valid = 1; coin = 2'b01; tick();
            sel_valid = 1; sel = 2'd1; tick();
            tick();
        end
        coin_valid = 1; coin = 2'b01; tick();
        sel_valid = 1; sel = 2'd1; tick();
        check_eq("soldout_err", sel_err, 2);
        check_eq("soldout_credit", credit, 1);
        restock = 1; restock_item = 2'd1; restock_qty = 4'd5; tick();
        sel_valid = 1; sel = 2'd1; tick();
        check_eq("restock_dispense", dispense, 1);
        tick();

        // Cancel with 2 units, ready pattern 1,0,1.
        coin_valid = 1; coin = 2'b10; tick();
        cancel = 1; tick();
        change_ready = 1; tick();
        change_ready = 0; tick();
        change_ready = 1; tick();
        check_eq("cancel_done_credit", credit, 0);
        check_eq("cancel_done_valid", change_valid, 0);
        coin_valid = 1; coin = 2'b10; tick();
        cancel = 1; tick();
        change_ready = 1; tick();
        rst = 0; tick();
        check_eq("midchange_rst_credit", credit, 0);
        check_eq("midchange_rst_valid", change_valid, 0);

        // Idle credit: refunded with the timeout, held without it.
        coin_valid = 1; coin = 2'b01; tick();
        repeat (20) begin
            change_ready = 1; tick();
        end
`ifdef VEND_TIMEOUT_EN
        check_eq("timeout_credit", credit, 0);
`else
        check_eq("held_credit", credit, 1);
`endif

        // Random traffic; later half has sparse coins so timeouts can occur.
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 399) != 0);
            coin_valid   = (c < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 14) == 0);
            coin         = 2'($urandom_range(0, 3));
            sel_valid    = ($urandom_range(0, 7) == 0);
            sel          = 2'($urandom_range(0, 3));
            cancel       = ($urandom_range(0, 29) == 0);
            restock      = ($urandom_range(0, 19) == 0);
            restock_item = 2'($urandom_range(0, 3));
            restock_qty  = 4'($urandom);
            change_ready = 1'($urandom_range(0, 1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_multi.md
# vend_ctrl_multi

Parametrised multi-item vending controller. It accepts Rs.5, Rs.10 and Rs.20 coins into a saturating credit register and tracks per-item stock with a restock port. It dispenses the selected item when credit covers its price, then pays change out one Rs.5 unit at a time over a ready/valid handshake. It sits between the coin-acceptor and keypad front end and the dispense and change-hopper drivers.

## Interface
- ITEM_N, 4, number of items; ISEL_W = $clog2(ITEM_N), minimum 1
- UNIT_W, 6, credit width in Rs.5 units; MAX_CREDIT = 2^UNIT_W-1
- PRICES, {4{6'd3}}, packed per-item price in Rs.5 units; item i at [i*UNIT_W +: UNIT_W]; every price must be nonzero
- STOCK_W, 4, per-item stock counter width
- INIT_STOCK, 4'd8, stock loaded into every item at reset
- TIMEOUT_CYC, 1000, idle-credit refund timeout in clk cycles
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- coin_valid  in  1  coin present this cycle
- coin  in  2  01=Rs.5 (1 unit), 10=Rs.10 (2), 11=Rs.20 (4), 00=invalid
- sel_valid  in  1  selection strobe
- sel  in  ISEL_W  selected item
- cancel  in  1  refund request
- restock  in  1  restock strobe
- restock_item  in  ISEL_W  item to restock
- restock_qty  in  STOCK_W  quantity to add
- change_ready  in  1  hopper accepts one Rs.5 unit
- coin_reject  out  1  one-cycle pulse: coin refused
- dispense  out  1  one-cycle pulse: release item
- dispense_item  out  ISEL_W  item being released, valid with dispense
- sel_err  out  2  one-cycle code: 01 insufficient credit, 10 sold out, 11 selection out of range
- change_valid  out  1  change unit pending
- credit  out  UNIT_W  current credit
- busy  out  1  high in DISPENSE and CHANGE
- timeout_evt  out  1  one-cycle pulse: timeout refund started

## Operation
- States: IDLE (credit=0), CREDIT, DISPENSE, CHANGE.
- Per-cycle priority in IDLE and CREDIT: cancel > sel_valid > coin_valid. A coin arriving together with an accepted cancel or sel is rejected with a coin_reject pulse.
- Coin: accepted only in IDLE or CREDIT. Code 00 is rejected. A coin that would push credit past MAX_CREDIT is rejected and credit is unchanged. An accepted coin adds 1, 2 or 4 units to credit and moves the FSM to CREDIT.
- Any coin_valid in DISPENSE or CHANGE is rejected.
- Selection, checked in this order:
  - sel >= ITEM_N: sel_err=11.
  - stock[sel]==0: sel_err=10.
  - credit < price: sel_err=01.
  - Otherwise: credit -= price, stock[sel] -= 1, FSM goes to DISPENSE.
- A rejected selection leaves state, credit and stock unchanged.
- DISPENSE lasts exactly one cycle with dispense=1. Next state is CHANGE if credit>0, else IDLE.
- CHANGE: change_valid=1 while credit>0. On each cycle with change_ready=1, credit decrements by 1. When credit reaches 0, FSM goes to IDLE and change_valid drops in that same update.
- Cancel: with credit>0, FSM goes to CHANGE. In IDLE, cancel is ignored.
- Restock is honoured in any state: stock[item] += qty, saturating at 2^STOCK_W-1. An out-of-range restock_item is ignored. Restock and dispense of the same item in the same cycle produce sat(stock+qty)-1.
- Reset, including mid-DISPENSE or mid-CHANGE: state IDLE, credit=0 (pending change is forfeited), stock=INIT_STOCK for every item, all outputs 0.

## Timing
- All outputs are registered.
- Coin or selection sampled at edge N: credit, coin_reject and sel_err reflect it after edge N. dispense is high for the cycle after edge N.
- First change_valid is the cycle after DISPENSE, or the cycle after the accepted cancel.
- Payout throughput: 1 unit per cycle while change_ready is held high.
- Timeout counter clears on any coin_valid or sel_valid.

## Configuration
- VEND_TIMEOUT_EN defined:
  - In CREDIT, after TIMEOUT_CYC consecutive cycles with no coin_valid and no sel_valid, FSM goes to CHANGE.
  - timeout_evt pulses for one cycle at that transition.
- VEND_TIMEOUT_EN undefined:
  - No counter is built and credit is held indefinitely.
  - timeout_evt is tied to 0.

## Test plan
- Reset, item0 price 3: coins 01,01,01, then sel=0 → credit 1,2,3; dispense pulse with item 0; credit 0; stock[0]=7; no change_valid.
- Coins 11,10 (6 units), sel=0, change_ready=1 → dispense, then 3 cycles of change_valid; credit 3→0; return to IDLE.
- Credit 62 (UNIT_W=6), coin 10 → coin_reject, credit stays 62. Separately, coin 01 together with sel_valid → coin_reject, selection processed.
- Stock[1] drained to 0, sel=1 with sufficient credit → sel_err=10, credit unchanged. Restock item1 qty 5 → next sel=1 dispenses and stock becomes 4.
- Credit 2, cancel, change_ready toggling 1,0,1 → exactly 2 payout units over 3 cycles, then IDLE. Repeat with reset asserted mid-CHANGE → credit 0, change_valid 0 next cycle.
- With VEND_TIMEOUT_EN, TIMEOUT_CYC=10: coin 01 then idle → timeout_evt at cycle 10 after the coin, followed by 1 unit of change. Without the macro → credit 1 still held after 20 cycles.
